// File: rtl/grf_wb.sv
// 32 x 32-bit MIPS general register file sitting on the write-back stage.
// Two combinational read ports with optional write bypass, a retire trace record and a retire counter.
module grf_wb #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WBValid,
  input  logic             RegWE,
  input  logic [4:0]       WriteAddr,
  input  logic [31:0]      RegData,
  input  logic [31:0]      WBPC,
  input  logic [4:0]       RsAddr,
  input  logic [4:0]       RtAddr,
  output logic [31:0]      RsData,
  output logic [31:0]      RtData,
  output logic             TraceValid,
  output logic [31:0]      TracePC,
  output logic [4:0]       TraceAddr,
  output logic [31:0]      TraceData,
  output logic [CNT_W-1:0] RetireCnt
);

  logic [31:0][31:0] regs_q;
  logic              we;

  logic              traceValid_q, traceValid_d;
  logic [31:0]       tracePC_q, tracePC_d;
  logic [4:0]        traceAddr_q, traceAddr_d;
  logic [31:0]       traceData_q, traceData_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Gating on WBValid first keeps X on the other write inputs from reaching state.
  assign we = WBValid & RegWE & (WriteAddr != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
    end else if (we) begin
      regs_q[WriteAddr] <= RegData;
    end
  end

  always_comb begin
    RsData = (RsAddr == 5'd0) ? 32'd0 : regs_q[RsAddr];
    RtData = (RtAddr == 5'd0) ? 32'd0 : regs_q[RtAddr];
    // we already excludes $0, so the bypass can never expose a write to register 0.
    if ((BYPASS != 0) && we && (RsAddr == WriteAddr)) RsData = RegData;
    if ((BYPASS != 0) && we && (RtAddr == WriteAddr)) RtData = RegData;
  end

  always_comb begin
    traceValid_d = WBValid;
    tracePC_d    = tracePC_q;
    traceAddr_d  = traceAddr_q;
    traceData_d  = traceData_q;
    cnt_d        = cnt_q;
    if (WBValid) begin
      tracePC_d   = WBPC;
      traceAddr_d = we ? WriteAddr : 5'd0;
      traceData_d = we ? RegData : 32'd0;
      cnt_d       = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      traceValid_q <= 1'b0;
      tracePC_q    <= '0;
      traceAddr_q  <= '0;
      traceData_q  <= '0;
      cnt_q        <= '0;
    end else begin
      traceValid_q <= traceValid_d;
      tracePC_q    <= tracePC_d;
      traceAddr_q  <= traceAddr_d;
      traceData_q  <= traceData_d;
      cnt_q        <= cnt_d;
    end
  end

  assign TraceValid = traceValid_q;
  assign TracePC    = tracePC_q;
  assign TraceAddr  = traceAddr_q;
  assign TraceData  = traceData_q;
  assign RetireCnt  = cnt_q;

endmodule

// File: tb/tb_grf_wb.sv
// Bench for grf_wb: bypass, non-bypass and 4-bit-counter instances share one stimulus stream.
// Vectors carry hand-derived read values; trace records flow through an expectation queue.
module tb_grf_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        WBValid, RegWE;
  logic [4:0]  WriteAddr, RsAddr, RtAddr;
  logic [31:0] RegData, WBPC;

  logic [31:0] rsB, rtB, tpcB, tdataB, cntB;
  logic        tvB;
  logic [4:0]  taddrB;
  logic [31:0] rsN, rtN, tpcN, tdataN, cntN;
  logic        tvN;
  logic [4:0]  taddrN;
  logic [31:0] rsC, rtC, tpcC, tdataC;
  logic        tvC;
  logic [4:0]  taddrC;
  logic [3:0]  cntC;

  grf_wb #(.BYPASS(1), .CNT_W(32)) uByp (
    .clk(clk), .reset(reset), .WBValid(WBValid), .RegWE(RegWE), .WriteAddr(WriteAddr),
    .RegData(RegData), .WBPC(WBPC), .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RsData(rsB), .RtData(rtB), .TraceValid(tvB), .TracePC(tpcB),
    .TraceAddr(taddrB), .TraceData(tdataB), .RetireCnt(cntB));

  grf_wb #(.BYPASS(0), .CNT_W(32)) uNoByp (
    .clk(clk), .reset(reset), .WBValid(WBValid), .RegWE(RegWE), .WriteAddr(WriteAddr),
    .RegData(RegData), .WBPC(WBPC), .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RsData(rsN), .RtData(rtN), .TraceValid(tvN), .TracePC(tpcN),
    .TraceAddr(taddrN), .TraceData(tdataN), .RetireCnt(cntN));

  grf_wb #(.BYPASS(1), .CNT_W(4)) uCnt4 (
    .clk(clk), .reset(reset), .WBValid(WBValid), .RegWE(RegWE), .WriteAddr(WriteAddr),
    .RegData(RegData), .WBPC(WBPC), .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RsData(rsC), .RtData(rtC), .TraceValid(tvC), .TracePC(tpcC),
    .TraceAddr(taddrC), .TraceData(tdataC), .RetireCnt(cntC));

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] expRs;
    logic [31:0] expRt;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } trace_t;

  vec_t        vecs[9];
  trace_t      expQ[$];
  trace_t      lastTrace;
  logic [31:0] model[32];
  int unsigned modelCnt;
  int          checks = 0;
  int          errors = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    modelCnt  = 0;
    lastTrace = '{valid: 1'b0, pc: 32'd0, addr: 5'd0, data: 32'd0};
  endtask

  // Called one time unit after a rising edge: compares the trace record and counters.
  task automatic checkOutput(input string tag);
    trace_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty actual=0 required=1", tag);
      return;
    end
    e = expQ.pop_front();
    checkVal({tag, ".TraceValid"}, {31'd0, tvB}, {31'd0, e.valid});
    checkVal({tag, ".TracePC"}, tpcB, e.pc);
    checkVal({tag, ".TraceAddr"}, {27'd0, taddrB}, {27'd0, e.addr});
    checkVal({tag, ".TraceData"}, tdataB, e.data);
    checkVal({tag, ".TraceValidNoByp"}, {31'd0, tvN}, {31'd0, e.valid});
    checkVal({tag, ".RetireCnt"}, cntB, modelCnt);
    checkVal({tag, ".RetireCntNoByp"}, cntN, modelCnt);
    checkVal({tag, ".RetireCnt4"}, {28'd0, cntC}, modelCnt % 16);
  endtask

  // Entered one time unit after a rising edge; leaves one time unit after the next.
  task automatic applyStimulus(input vec_t vc, input string tag);
    trace_t e;
    logic   weM;
    WBValid   = vc.v;
    RegWE     = vc.we;
    WriteAddr = vc.wa;
    RegData   = vc.wd;
    WBPC      = vc.pc;
    RsAddr    = vc.rs;
    RtAddr    = vc.rt;
    weM = (vc.v === 1'b1) && (vc.we === 1'b1) && (vc.wa != 5'd0);
    if (vc.v === 1'b1) begin
      e.valid = 1'b1;
      e.pc    = vc.pc;
      e.addr  = weM ? vc.wa : 5'd0;
      e.data  = weM ? vc.wd : 32'd0;
    end else begin
      e       = lastTrace;
      e.valid = 1'b0;
    end
    lastTrace = e;
    expQ.push_back(e);
    #4;
    checkVal({tag, ".RsByp"}, rsB, vc.expRs);
    checkVal({tag, ".RtByp"}, rtB, vc.expRt);
    checkVal({tag, ".RsNoByp"}, rsN, (vc.rs == 5'd0) ? 32'd0 : model[vc.rs]);
    checkVal({tag, ".RtNoByp"}, rtN, (vc.rt == 5'd0) ? 32'd0 : model[vc.rt]);
    @(posedge clk);
    if (weM) model[vc.wa] = vc.wd;
    if (vc.v === 1'b1) modelCnt++;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vec_t vw;
    vecs[0] = '{1'b1, 1'b1, 5'd5,  32'h12345678, 32'h3000, 5'd5,  5'd0, 32'h12345678, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h3004, 5'd0,  5'd5, 32'h0,        32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 5'd8,  32'h0000000A, 32'h3008, 5'd0,  5'd5, 32'h0,        32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 5'd8,  32'h0000000B, 32'h300C, 5'd8,  5'd8, 32'hB,        32'hB};
    vecs[4] = '{1'b1, 1'b0, 5'd9,  32'hDEADBEEF, 32'h3004, 5'd9,  5'd8, 32'h0,        32'hB};
    vecs[5] = '{1'b0, 1'b1, 5'd10, 32'h00000077, 32'h4000, 5'd10, 5'd8, 32'h0,        32'hB};
    vecs[6] = '{1'b1, 1'b1, 5'd8,  32'h0000000C, 32'h3010, 5'd8,  5'd5, 32'hC,        32'h12345678};
    vecs[7] = '{1'b0, 1'bx, 5'bx,  32'hx,        32'hx,    5'd8,  5'd0, 32'hC,        32'h0};
    vecs[8] = '{1'b1, 1'b1, 5'd3,  32'h00000055, 32'h3014, 5'd3,  5'd3, 32'h55,       32'h55};

    reset = 1'b0;
    WBValid = 1'b0; RegWE = 1'b0; WriteAddr = 5'd0; RegData = 32'd0; WBPC = 32'd0;
    RsAddr = 5'd5; RtAddr = 5'd8;
    resetModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkVal("reset.RsData", rsB, 32'd0);
    checkVal("reset.TraceValid", {31'd0, tvB}, 32'd0);
    checkVal("reset.TracePC", tpcB, 32'd0);
    checkVal("reset.RetireCnt", cntB, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset asserted between clock edges must clear everything at once.
    WBValid = 1'b0; RegWE = 1'b0; RsAddr = 5'd3; RtAddr = 5'd3;
    #2;
    checkVal("preReset.Rs3", rsB, 32'h55);
    reset = 1'b0;
    #1;
    checkVal("midReset.Rs3", rsB, 32'd0);
    checkVal("midReset.Rt3NoByp", rtN, 32'd0);
    checkVal("midReset.TraceValid", {31'd0, tvB}, 32'd0);
    checkVal("midReset.TracePC", tpcB, 32'd0);
    checkVal("midReset.TraceAddr", {27'd0, taddrB}, 32'd0);
    checkVal("midReset.TraceData", tdataB, 32'd0);
    checkVal("midReset.RetireCnt", cntB, 32'd0);
    checkVal("midReset.RetireCnt4", {28'd0, cntC}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    resetModel();
    vw = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 32'd0, 32'd0};
    applyStimulus(vw, "postReset");

    // Seventeen retires wrap the 4-bit counter back to 1.
    for (int i = 0; i < 17; i++) begin
      vw = '{1'b1, 1'b0, 5'd9, 32'hCAFE0000 + i, 32'h5000 + 4 * i, 5'd3, 5'd8, 32'd0, 32'd0};
      applyStimulus(vw, $sformatf("wrap%0d", i));
    end
    checkVal("wrap.RetireCnt4", {28'd0, cntC}, 32'd1);
    checkVal("wrap.RetireCnt", cntB, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_wb.md
Name: grf_wb

Overview:
- 32 x 32-bit general register file at the tail of the 5-stage MIPS pipeline.
- Consumes the write-back stage outputs (destination address, write data) and supplies ID-stage operands on two read ports.
- Registers a per-retire trace record (PC, destination, data) and keeps a retired-instruction counter for the verification bench and debug.

Parameters:
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
WBValid  input  1  an instruction retires in WB this cycle
RegWE  input  1  retiring instruction writes the GRF; ignored unless WBValid=1
WriteAddr  input  5  destination register from write-back select
RegData  input  32  write data from write-back select
WBPC  input  32  PC of the retiring instruction
RsAddr  input  5  read port 1 address
RtAddr  input  5  read port 2 address
RsData  output  32  read port 1 data, combinational
RtData  output  32  read port 2 data, combinational
TraceValid  output  1  trace record valid, one cycle pulse
TracePC  output  32  PC of traced instruction
TraceAddr  output  5  destination written (0 if no write)
TraceData  output  32  data written (0 if no write)
RetireCnt  output  CNT_W  count of retired instructions

Behaviour:
- Reset (reset=0, asynchronous): all 32 registers = 0, TraceValid=0, TracePC=0, TraceAddr=0, TraceData=0, RetireCnt=0. Reset has priority over any write in the same cycle. Outputs hold these values while reset=0.
- Effective write: we = WBValid & RegWE & (WriteAddr != 0). On a rising edge with we=1, register[WriteAddr] <= RegData.
- Register 0 is never written and always reads 0, including through the bypass path.
- Reads: RsData = register[RsAddr] and RtData = register[RtAddr], zero latency.
- BYPASS=1: if we=1 and the read address equals WriteAddr, the read port returns RegData in the same cycle. Each port is evaluated independently, so both ports may bypass at once.
- BYPASS=0: a read in the write cycle returns the old value; the new value is visible from the next cycle.
- Trace: on a rising edge with WBValid=1, TraceValid <= 1 and TracePC <= WBPC.
  - TraceAddr/TraceData <= WriteAddr/RegData when we=1; otherwise both <= 0. This covers RegWE=0 and writes targeting $0.
- Trace with WBValid=0: on a rising edge, TraceValid <= 0 and the other trace fields hold their previous values.
- Trace latency: exactly one cycle after the retire cycle.
- RetireCnt increments by 1 on every rising edge with WBValid=1, independent of RegWE. It wraps modulo 2^CNT_W with no saturation.
- Inputs that are X while WBValid=0 must not corrupt state.
- Consecutive writes to the same register: the later write wins. With BYPASS=1, a read sees the value from the current cycle's write.

Test Plan:
- Reset, then WBValid=1, RegWE=1, WriteAddr=5, RegData=0x12345678, WBPC=0x3000 for 1 cycle -> next cycle TraceValid=1, TracePC=0x3000, TraceAddr=5, TraceData=0x12345678, RetireCnt=1; later RsAddr=5 reads 0x12345678.
- WriteAddr=0, RegData=0xFFFFFFFF, WBValid=1, RegWE=1 -> RsAddr=0 reads 0 in the same and following cycles; trace shows TraceAddr=0, TraceData=0; RetireCnt increments.
- BYPASS=1: register 8 holds 0xA; write 0xB to 8 while RsAddr=RtAddr=8 -> both read 0xB in the same cycle. BYPASS=0: same stimulus -> 0xA in that cycle, 0xB in the next.
- WBValid=1, RegWE=0, WriteAddr=9, WBPC=0x3004 -> register 9 unchanged; TraceAddr=0, TraceData=0, TracePC=0x3004; RetireCnt increments.
- Write 0x55 to register 3, then assert reset=0 mid-cycle (not on a clock edge) -> register 3, trace fields and RetireCnt read 0 immediately; after release, register 3 reads 0.
- CNT_W=4: 17 consecutive retiring cycles -> RetireCnt = 1 (wrapped).
